// File: rtl/frame_decimator_2x.sv
// Halves an RGB565 pixel stream in both directions: horizontal pairs are averaged
// per channel, odd lines are dropped, and each output carries its linear address.
module frame_decimator_2x #(
  parameter int IN_WIDTH  = 640,
  parameter int IN_HEIGHT = 480,
  parameter int OUT_AW    = 17
) (
  input  logic              p_clock,
  input  logic              rst_n,
  input  logic [15:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  output logic [15:0]       out_data,
  output logic              out_valid,
  output logic [OUT_AW-1:0] out_addr,
  output logic              out_frame_done,
  output logic              overrun
);

  localparam int CW         = $clog2(IN_WIDTH);
  localparam int RW         = $clog2(IN_HEIGHT);
  localparam int OUT_PIXELS = IN_WIDTH * IN_HEIGHT / 4;

  localparam logic [CW-1:0]     COL_LAST  = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0]     ROW_LAST  = RW'(IN_HEIGHT - 1);
  localparam logic [OUT_AW-1:0] ADDR_LAST = OUT_AW'(OUT_PIXELS - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              full;
  logic              hold_valid;
  logic [15:0]       hold_data;
  logic [OUT_AW-1:0] addr_cnt;

  logic accept;
  logic pair_done;
  logic [5:0]  r_sum;
  logic [6:0]  g_sum;
  logic [5:0]  b_sum;
  logic [15:0] avg;

  assign accept    = pixel_valid && !full;
  assign pair_done = accept && !row[0] && col[0] && hold_valid;

  // Channel sums are one bit wider than the channel so the carry survives the halving.
  assign r_sum = {1'b0, hold_data[15:11]} + {1'b0, pixel_data[15:11]};
  assign g_sum = {1'b0, hold_data[10:5]}  + {1'b0, pixel_data[10:5]};
  assign b_sum = {1'b0, hold_data[4:0]}   + {1'b0, pixel_data[4:0]};
  assign avg   = {r_sum[5:1], g_sum[6:1], b_sum[5:1]};

  // NOTE: hold_data is pure datapath qualified by hold_valid, so it needs no reset;
  // keeping it out of the reset tree lets it map to plain flops.
  always_ff @(posedge p_clock) begin
    if (accept && !row[0] && !col[0]) begin
      hold_data <= pixel_data;
    end
  end

  // NOTE: all state uses non-blocking assignments; the frame_done clear is written
  // last so that it wins over any counter update made earlier in the same edge.
  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      col            <= '0;
      row            <= '0;
      full           <= 1'b0;
      hold_valid     <= 1'b0;
      addr_cnt       <= '0;
      overrun        <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_addr       <= '0;
      out_frame_done <= 1'b0;
    end else begin
      out_valid      <= 1'b0;
      out_frame_done <= frame_done;

      if (pixel_valid && full) begin
        overrun <= 1'b1;
      end

      if (accept) begin
        if (col == COL_LAST) begin
          if (row == ROW_LAST) begin
            full <= 1'b1;
          end else begin
            col <= '0;
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
        if (!row[0]) begin
          hold_valid <= !col[0];
        end
      end

      if (pair_done) begin
        out_valid <= 1'b1;
        out_data  <= avg;
        out_addr  <= addr_cnt;
        if (addr_cnt != ADDR_LAST) begin
          addr_cnt <= addr_cnt + 1'b1;
        end
      end

      // A pixel in the same cycle belongs to the ending frame; its output still fires.
      if (frame_done) begin
        col        <= '0;
        row        <= '0;
        addr_cnt   <= '0;
        hold_valid <= 1'b0;
        full       <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_frame_decimator_2x.sv
// Bench for frame_decimator_2x on a reduced 16x8 frame: a pixel-index model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_frame_decimator_2x;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int AW = 5;

  logic          p_clock = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   pixel_data = '0;
  logic          pixel_valid = 1'b0;
  logic          frame_done = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic          out_frame_done;
  logic          overrun;

  int n_checks = 0;
  int n_err    = 0;
  int n_out    = 0;
  logic [15:0]   last_data = '0;
  logic [AW-1:0] last_addr = '0;

  frame_decimator_2x #(.IN_WIDTH(W), .IN_HEIGHT(H), .OUT_AW(AW)) dut (
    .p_clock        (p_clock),
    .rst_n          (rst_n),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .frame_done     (frame_done),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_addr       (out_addr),
    .out_frame_done (out_frame_done),
    .overrun        (overrun)
  );

  initial forever #5 p_clock = ~p_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] avg565(input logic [15:0] a, input logic [15:0] b);
    int r, g, bl;
    r  = (int'(a[15:11]) + int'(b[15:11])) / 2;
    g  = (int'(a[10:5])  + int'(b[10:5]))  / 2;
    bl = (int'(a[4:0])   + int'(b[4:0]))   / 2;
    return {5'(r), 6'(g), 5'(bl)};
  endfunction

  // Model: position in the frame is just the count of accepted pixels.
  int            m_n;
  logic [15:0]   m_hold;
  logic          m_ovr;
  logic          exp_valid;
  logic          exp_fd;
  logic [15:0]   exp_data;
  logic [AW-1:0] exp_addr;

  always @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_ovr <= 1'b0; exp_valid <= 1'b0; exp_fd <= 1'b0;
      exp_data <= '0; exp_addr <= '0;
    end else begin
      exp_valid <= 1'b0;
      exp_fd    <= frame_done;
      if (pixel_valid) begin
        if (m_n >= W * H) begin
          m_ovr <= 1'b1;
        end else begin
          if ((m_n / W) % 2 == 0) begin
            if (m_n % 2 == 0) begin
              m_hold <= pixel_data;
            end else begin
              exp_valid <= 1'b1;
              exp_data  <= avg565(m_hold, pixel_data);
              exp_addr  <= AW'((m_n / W / 2) * (W / 2) + (m_n % W) / 2);
            end
          end
          m_n <= m_n + 1;
        end
      end
      if (frame_done) begin
        m_n   <= 0;
        m_ovr <= 1'b0;
      end
    end
  end

  always @(negedge p_clock) begin
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("out_data", 32'(out_data), 32'(exp_data));
    check("out_addr", 32'(out_addr), 32'(exp_addr));
    check("out_frame_done", 32'(out_frame_done), 32'(exp_fd));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (out_valid) begin
      n_out     <= n_out + 1;
      last_data <= out_data;
      last_addr <= out_addr;
    end
  end

  task automatic tick(input logic v, input logic [15:0] d, input logic fd);
    @(negedge p_clock);
    #1;
    pixel_valid = v;
    pixel_data  = d;
    frame_done  = fd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic feed(input int n, input logic [15:0] seed, input bit gaps);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, seed ^ 16'(i * 16'h1357), 1'b0);
      if (gaps) tick(1'b0, 16'h0000, 1'b0);
    end
  endtask

  task automatic pair(input logic [15:0] a, input logic [15:0] b);
    tick(1'b1, a, 1'b0);
    tick(1'b1, b, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic restart();
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
  endtask

  int base;

  initial begin
    // Reset with random inputs.
    for (int i = 0; i < 5; i++) tick(1'($urandom), 16'($urandom), 1'($urandom));
    check("rst out_data", 32'(out_data), 32'h0);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_addr", 32'(out_addr), 32'h0);
    check("rst out_frame_done", 32'(out_frame_done), 32'h0);
    check("rst overrun", 32'(overrun), 32'h0);
    tick(1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;

    // First pair after reset.
    pair(16'hFFFF, 16'h0000);
    check("first pair count", 32'(n_out), 32'd1);
    check("first pair data", 32'(last_data), 32'h7BEF);
    check("first pair addr", 32'(last_addr), 32'd0);

    // Even line with gaps, then an odd line back-to-back.
    restart();
    base = n_out;
    feed(W, 16'hA5A5, 1'b1);
    idle(1);
    check("even line outputs", 32'(n_out - base), 32'(W / 2));
    check("even line last addr", 32'(last_addr), 32'(W / 2 - 1));
    base = n_out;
    feed(W, 16'h3C3C, 1'b0);
    idle(1);
    check("odd line outputs", 32'(n_out - base), 32'd0);

    // Full constant frame.
    restart();
    base = n_out;
    for (int i = 0; i < W * H; i++) tick(1'b1, 16'h0841, 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    check("frame outputs", 32'(n_out - base), 32'(W * H / 4));
    check("frame last data", 32'(last_data), 32'h0841);
    check("frame last addr", 32'(last_addr), 32'(W * H / 4 - 1));
    check("frame out_frame_done", 32'(out_frame_done), 32'd1);
    check("frame overrun", 32'(overrun), 32'd0);
    idle(1);
    check("frame out_frame_done pulse", 32'(out_frame_done), 32'd0);

    // Overrun: one pixel beyond a full frame.
    base = n_out;
    feed(W * H, 16'h5A5A, 1'b0);
    tick(1'b1, 16'hFFFF, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    check("overrun set", 32'(overrun), 32'd1);
    check("overrun outputs", 32'(n_out - base), 32'(W * H / 4));
    restart();
    check("overrun cleared", 32'(overrun), 32'd0);
    pair(16'hF800, 16'h07E0);
    check("post-overrun addr", 32'(last_addr), 32'd0);
    check("post-overrun data", 32'(last_data), 32'h7BE0);

    // Odd pixel of a pair coincident with frame_done.
    restart();
    pair(16'h1111, 16'h3333);
    tick(1'b1, 16'h5555, 1'b0);
    tick(1'b1, 16'h7777, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    check("coincident addr", 32'(last_addr), 32'd1);
    check("coincident data", 32'(last_data), 32'h6656);
    check("coincident out_frame_done", 32'(out_frame_done), 32'd1);
    pair(16'h0000, 16'h0002);
    check("new frame addr", 32'(last_addr), 32'd0);
    check("new frame data", 32'(last_data), 32'h0001);

    // Even pixel coincident with frame_done: the half pair is discarded.
    base = n_out;
    tick(1'b1, 16'hFFFF, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    check("half pair no output", 32'(n_out - base), 32'd0);
    pair(16'h0002, 16'h0004);
    check("after half pair addr", 32'(last_addr), 32'd0);
    check("after half pair data", 32'(last_data), 32'h0003);

    // Mid-line reset.
    restart();
    feed(11, 16'hC3C3, 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midline rst out_data", 32'(out_data), 32'h0);
    check("midline rst out_addr", 32'(out_addr), 32'h0);
    check("midline rst out_valid", 32'(out_valid), 32'h0);
    idle(2);
    rst_n = 1'b1;
    pair(16'hFFFF, 16'h0000);
    check("midline pair addr", 32'(last_addr), 32'd0);
    check("midline pair data", 32'(last_data), 32'h7BEF);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
